// File: rtl/mtf4_pkg.sv
// Shared constants for the last-unique-4 move-to-front list (decoder and encoder sides).
package mtf4_pkg;
  localparam int LIST_DEPTH     = 4;
  localparam int IDX_W          = 2;
  localparam int DATA_W_DEFAULT = 8;

  localparam logic SYM_LITERAL = 1'b0;
  localparam logic SYM_INDEX   = 1'b1;

  // Entries are unique, so at most one bit of a match vector is ever set.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [LIST_DEPTH-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = LIST_DEPTH - 1; k >= 0; k--) begin
      if (vec[k]) idx = IDX_W'(k);
    end
    return idx;
  endfunction
endpackage

// File: rtl/mtf4_list.sv
// Four-entry most-recent-unique list: insert-at-front or move-to-front on the edge with upd=1.
// Match against new_val is combinational on the current (pre-update) contents.
module mtf4_list
  import mtf4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             upd,
  input  logic                             hit,
  input  logic [IDX_W-1:0]                 hit_pos,
  input  logic [DATA_W-1:0]                new_val,
  output logic [LIST_DEPTH-1:0][DATA_W-1:0] entries,
  output logic [LIST_DEPTH-1:0]            valid,
  output logic [LIST_DEPTH-1:0]            match_vec,
  output logic [IDX_W-1:0]                 match_pos
);

  // Invalid slots are excluded so stale data can never alias a literal.
  always_comb begin
    match_vec = '0;
    for (int k = 0; k < LIST_DEPTH; k++) begin
      match_vec[k] = valid[k] && (entries[k] == new_val);
    end
  end

  assign match_pos = onehot_to_idx(match_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      entries <= '0;
      valid   <= '0;
    end else if (upd) begin
      if (hit) begin
        entries[0] <= entries[hit_pos];
        for (int k = 1; k < LIST_DEPTH; k++) begin
          if (k <= int'(hit_pos)) entries[k] <= entries[k-1];
        end
      end else begin
        entries[0] <= new_val;
        for (int k = 1; k < LIST_DEPTH; k++) begin
          entries[k] <= entries[k-1];
        end
        valid <= {valid[LIST_DEPTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/mtf4_decoder.sv
// Move-to-front decoder: literal/index symbols in, reconstructed bytes out one cycle after acceptance.
// Single output register; in_ready = !out_valid || out_ready, so full rate while downstream is ready.
module mtf4_decoder
  import mtf4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_index,
  input  logic [1:0]        in_index,
  input  logic [DATA_W-1:0] in_literal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] list_0,
  output logic [DATA_W-1:0] list_1,
  output logic [DATA_W-1:0] list_2,
  output logic [DATA_W-1:0] list_3,
  output logic [3:0]        list_valid,
  output logic              err
);

  logic [LIST_DEPTH-1:0][DATA_W-1:0] entries;
  logic [LIST_DEPTH-1:0]             match_vec;
  logic [IDX_W-1:0]                  match_pos;
  logic                              accept;
  logic                              sym_is_idx;
  logic                              idx_ok;
  logic                              produce;
  logic                              lst_hit;
  logic [IDX_W-1:0]                  lst_pos;
  logic [DATA_W-1:0]                 sym_val;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign sym_is_idx = (in_is_index == SYM_INDEX);
  assign idx_ok     = list_valid[in_index];

  // A literal already in the list is handled as an index to its position.
  assign produce = accept && (!sym_is_idx || idx_ok);
  assign lst_hit = sym_is_idx || (|match_vec);
  assign lst_pos = sym_is_idx ? in_index : match_pos;
  assign sym_val = sym_is_idx ? entries[in_index] : in_literal;

  mtf4_list #(
    .DATA_W(DATA_W)
  ) u_list (
    .clk      (clk),
    .rst      (rst),
    .upd      (produce),
    .hit      (lst_hit),
    .hit_pos  (lst_pos),
    .new_val  (in_literal),
    .entries  (entries),
    .valid    (list_valid),
    .match_vec(match_vec),
    .match_pos(match_pos)
  );

  assign list_0 = entries[0];
  assign list_1 = entries[1];
  assign list_2 = entries[2];
  assign list_3 = entries[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      if (accept && sym_is_idx && !idx_ok) err <= 1'b1;
      if (produce) begin
        out_valid <= 1'b1;
        out_data  <= sym_val;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtf4_decoder.sv
// Bench for mtf4_decoder: queue-based list model checked every cycle, plus directed literal checks.
module tb_mtf4_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_is_index = 1'b0;
  logic [1:0] in_index = 2'd0;
  logic [7:0] in_literal = 8'd0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] list_0, list_1, list_2, list_3;
  logic [3:0] list_valid;
  logic       err;

  mtf4_decoder #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_index(in_is_index),
    .in_index   (in_index),
    .in_literal (in_literal),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .list_0     (list_0),
    .list_1     (list_1),
    .list_2     (list_2),
    .list_3     (list_3),
    .list_valid (list_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0] dl [4];
  always_comb begin
    dl[0] = list_0;
    dl[1] = list_1;
    dl[2] = list_2;
    dl[3] = list_3;
  end

  // Reference: list as a queue with the most recent value at the front.
  logic [7:0] mq [$];
  logic       m_ov = 1'b0;
  logic [7:0] m_od = 8'd0;
  logic       m_err = 1'b0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin : model
    int k;
    logic [7:0] v;
    bit prod;
    if (rst) begin
      mq.delete();
      m_ov  = 1'b0;
      m_od  = 8'd0;
      m_err = 1'b0;
    end else begin
      prod = 1'b0;
      v    = 8'd0;
      if (in_valid && (!m_ov || out_ready)) begin
        k = -1;
        if (in_is_index) begin
          k = (int'(in_index) < mq.size()) ? int'(in_index) : -2;
        end else begin
          foreach (mq[i]) if (mq[i] == in_literal) k = i;
        end
        if (k == -2) begin
          m_err = 1'b1;
        end else if (k == -1) begin
          mq.push_front(in_literal);
          if (mq.size() > 4) void'(mq.pop_back());
          v    = in_literal;
          prod = 1'b1;
        end else begin
          v = mq[k];
          mq.delete(k);
          mq.push_front(v);
          prod = 1'b1;
        end
      end
      if (prod) begin
        m_ov = 1'b1;
        m_od = v;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, !m_ov || out_ready);
      check("out_valid", out_valid, m_ov);
      if (m_ov) check("out_data", out_data, m_od);
      check("err", err, m_err);
      check("list_valid", list_valid, (1 << mq.size()) - 1);
      for (int k = 0; k < mq.size(); k++) check($sformatf("list_%0d", k), dl[k], mq[k]);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // arg is the literal, or the index in its low two bits for index symbols.
  task automatic sym(input logic ii, input logic [7:0] arg);
    in_valid    = 1'b1;
    in_is_index = ii;
    in_index    = arg[1:0];
    in_literal  = arg;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sym_exp(input string name, input logic ii, input logic [7:0] arg, input logic [7:0] exp);
    sym(ii, arg);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, out_data, exp);
  endtask

  task automatic chk_list(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input logic [3:0] vb);
    check({name, "_l0"}, list_0, a);
    check({name, "_l1"}, list_1, b);
    check({name, "_l2"}, list_2, c);
    check({name, "_l3"}, list_3, d);
    check({name, "_lv"}, list_valid, vb);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    chk_list("rst", 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000);

    out_ready = 1'b1;
    sym_exp("a1", 1'b0, 8'd1, 8'd1);
    sym_exp("a2", 1'b0, 8'd9, 8'd9);
    sym_exp("a3", 1'b0, 8'd2, 8'd2);
    sym_exp("a4", 1'b0, 8'd3, 8'd3);
    chk_list("a", 8'd3, 8'd2, 8'd9, 8'd1, 4'b1111);

    sym_exp("b1", 1'b0, 8'd4, 8'd4);
    sym_exp("b2", 1'b1, 8'd1, 8'd3);
    sym_exp("b3", 1'b0, 8'd7, 8'd7);
    sym_exp("b4", 1'b1, 8'd0, 8'd7);
    sym_exp("b5", 1'b0, 8'd1, 8'd1);
    sym_exp("b6", 1'b1, 8'd0, 8'd1);
    chk_list("b", 8'd1, 8'd7, 8'd3, 8'd4, 4'b1111);

    do_reset();
    sym(1'b1, 8'd2);
    check("e_out_valid", out_valid, 0);
    check("e_err", err, 1);
    check("e_lv", list_valid, 4'b0000);
    sym_exp("e5", 1'b0, 8'd5, 8'd5);
    check("e_err_sticky", err, 1);

    do_reset();
    sym(1'b0, 8'd1);
    sym(1'b0, 8'd9);
    sym(1'b0, 8'd2);
    sym(1'b0, 8'd3);
    sym_exp("dup", 1'b0, 8'd9, 8'd9);
    chk_list("dup", 8'd9, 8'd3, 8'd2, 8'd1, 4'b1111);

    do_reset();
    out_ready = 1'b0;
    sym_exp("bp1", 1'b0, 8'd1, 8'd1);
    in_valid    = 1'b1;
    in_is_index = 1'b0;
    in_literal  = 8'd2;
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_data", out_data, 8'd1);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    sym_exp("bp2", 1'b0, 8'd2, 8'd2);
    sym_exp("bp3", 1'b0, 8'd3, 8'd3);
    chk_list("bp", 8'd3, 8'd2, 8'd1, 8'd0, 4'b0111);

    do_reset();
    sym_exp("mr1", 1'b0, 8'd8, 8'd8);
    rst         = 1'b1;
    in_valid    = 1'b1;
    in_is_index = 1'b0;
    in_literal  = 8'd6;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mr_out_valid", out_valid, 0);
    check("mr_err", err, 0);
    chk_list("mr", 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000);
    sym_exp("mr2", 1'b0, 8'd1, 8'd1);
    chk_list("mr2", 8'd1, 8'd0, 8'd0, 8'd0, 4'b0001);

    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_is_index = 1'($urandom_range(0, 1));
      in_index    = 2'($urandom_range(0, 3));
      in_literal  = 8'($urandom_range(0, 6));
      out_ready   = ($urandom_range(0, 9) < 7);
      rst         = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mtf4_decoder.md
# mtf4_decoder

Move-to-front decoder for the 4-entry last-unique-value scheme.
- Consumes a symbol stream where each symbol is either a literal byte or a 2-bit index into a 4-deep most-recent-unique list.
- Reconstructs the original data stream and keeps its own copy of the list.
- Acts as the receive-side counterpart of the last-unique-4 tracker/encoder; both ends hold identical lists when fed the same data.

## Interface
Parameters:
- DATA_W, 8: width of literals, list entries and output data.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  symbol present.
- in_ready  output  1  decoder accepts the symbol this cycle.
- in_is_index  input  1  1 = index symbol, 0 = literal symbol.
- in_index  input  2  list position; used when in_is_index=1.
- in_literal  input  DATA_W  literal value; used when in_is_index=0.
- out_valid  output  1  decoded byte present.
- out_ready  input  1  downstream accepts the byte.
- out_data  output  DATA_W  decoded byte.
- list_0..list_3  output  DATA_W each  current list; list_0 is the most recent entry.
- list_valid  output  4  per-entry occupancy; bit k belongs to list_k.
- err  output  1  sticky flag: an index pointed at an empty entry.

## Operation
- Accept condition: in_valid && in_ready. A symbol is consumed only on this condition.
- Literal L, no entry matches: shift the list down one place (list_k+1 ← list_k); list_0 ← L; list_valid ← {list_valid[2:0],1}. The old list_3 is dropped. out_data ← L.
- Literal L equal to a valid entry list_k: treat it exactly as index k. Move-to-front, no duplicate inserted.
- Index k, list_valid[k]=1: out_data ← list_k. Move-to-front:
  - list_0 ← list_k;
  - entries 0..k-1 shift down one place;
  - entries above k are unchanged;
  - list_valid is unchanged.
  - k=0 leaves the list unchanged.
- Index k, list_valid[k]=0:
  - symbol is consumed;
  - no output is produced;
  - list is unchanged;
  - err ← 1, and stays 1 until rst.
- Matching compares only valid entries. Invalid entries never match.

## Timing
- Reset values: out_valid=0, out_data=0, list_0..3=0, list_valid=4'b0000, err=0. in_ready=1 after reset.
- Latency is 1 cycle. A symbol accepted at edge N gives out_valid=1 with the decoded byte after edge N. The list update is also visible after edge N.
- Output stage is a single register.
  - in_ready = !out_valid || out_ready (combinational).
  - out_valid clears after an edge where out_ready=1 and no new symbol is accepted.
- Full throughput of one symbol per cycle while out_ready=1.
- Back-to-back symbols see the list as updated by the previous symbol. There is no hazard window.
- out_data and out_valid hold stable while out_valid=1 && out_ready=0.
- rst asserted mid-stream has priority over everything in that cycle:
  - the in-flight output is discarded;
  - the list and err are cleared;
  - the symbol presented in that cycle is not consumed.
- An error symbol accepted while the output stage is idle leaves out_valid=0.

## Structure
- Shared package mtf4_pkg: LIST_DEPTH=4, IDX_W=2, the symbol-kind constants (SYM_LITERAL=0, SYM_INDEX=1), and DATA_W default.
- Sub-module mtf4_list holds the list storage and occupancy.
  - Inputs: clk, rst, update enable, hit flag, hit position, new value.
  - Outputs: entries, valid bits, parallel match vector plus encoded match position.
  - Reused unchanged by the encoder side.
- The top level contains the symbol decode, error flag and output register.

## Test plan
- Literals 1,9,2,3 with out_ready=1 → outputs 1,9,2,3, one per cycle, each 1 cycle after acceptance. Final list [3,2,9,1], list_valid=1111.
- Continue with literal 4, index 1, literal 7, index 0, literal 1, index 0 → outputs 4,3,7,7,1,1. Final list [1,7,3,4].
- After reset, index 2 → no output, err=1, list_valid=0000. Then literal 5 → output 5; err stays 1.
- Literal 9 while list is [3,2,9,1] → output 9, list becomes [9,3,2,1], list_valid unchanged (duplicate-literal path).
- Hold out_ready=0 for 3 cycles during a stream:
  - in_ready drops after the first output;
  - out_data stays stable;
  - no symbol is lost or duplicated;
  - the remaining outputs resume in order once out_ready=1.
- Assert rst in the cycle after a symbol is accepted → next cycle out_valid=0, list all 0, list_valid=0000, err=0. The stream restarts cleanly with literal 1 → output 1.
